tcam_ctrl7x64: RTL and testbench

- Initiator for the 7-bit-key × 64-entry SRAM-backed TCAM macro. That macro stores, for every 7-bit key, a 64-bit match vector.
  - Rows 0..127 hold match bits 31:0; rows 128..255 hold match bits 63:32.
  - A read at key k returns both halves.
- This block turns host requests into macro port sequences: SEARCH, WRITE (program entry key/mask) and DELETE. It also priority-encodes search results.
- It sits between the RoCC command decoder and the TCAM macro.

---
 rtl/tcam_ctrl7x64.sv | 211 +++++++++++++++++++++
 tb/tb_tcam_ctrl7x64.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_ctrl7x64.sv
// tcam_ctrl7x64: request sequencer for the 7-bit-key x 64-entry SRAM-backed TCAM.
// SEARCH reads one row pair and priority-encodes it; WRITE/DELETE sweep all 128
// rows, read-modify-writing the entry's bit in the half that holds it.
module tcam_ctrl7x64 #(
    parameter int RD_LAT = 1
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_req_valid,
    output logic        out_req_ready,
    input  logic [1:0]  in_req_op,
    input  logic [6:0]  in_req_key,
    input  logic [6:0]  in_req_mask,
    input  logic [5:0]  in_req_idx,
    output logic        out_rsp_valid,
    output logic        out_rsp_hit,
    output logic [5:0]  out_rsp_idx,
    output logic [63:0] out_rsp_vec,
    output logic        out_busy,
    output logic        out_tcam_csb,
    output logic        out_tcam_web,
    output logic [3:0]  out_tcam_wmask,
    output logic [7:0]  out_tcam_addr,
    output logic [31:0] out_tcam_wdata,
    input  logic [63:0] in_tcam_rdata
);

    typedef enum logic [2:0] {IDLE, S_RD, S_WAIT, RSP, P_RD, P_WAIT, P_WR} state_t;

    localparam logic [1:0] OP_SEARCH = 2'd0;
    localparam logic [1:0] OP_WRITE  = 2'd1;
    localparam logic [1:0] OP_DELETE = 2'd2;
    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(RD_LAT - 1);

    state_t         state_q, state_d;
    logic [6:0]     a_q, a_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [1:0]     op_q, op_d;
    logic [6:0]     key_q, key_d, mask_q, mask_d;
    logic [5:0]     idx_q, idx_d;

    logic           ready_q, busy_q;
    logic           csb_q, csb_d, web_q, web_d;
    logic [3:0]     wmask_q, wmask_d;
    logic [7:0]     addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           rv_q, rv_d, hit_q, hit_d;
    logic [5:0]     ridx_q, ridx_d;
    logic [63:0]    vec_q, vec_d;

    logic [31:0]    half;
    logic           bit_b;

    // Lowest set bit wins; returns 0 for an all-zero vector.
    function automatic logic [5:0] lsb_idx(input logic [63:0] v);
        lsb_idx = '0;
        for (int i = 63; i >= 0; i--)
            if (v[i]) lsb_idx = 6'(i);
    endfunction

    // Next state plus next registered outputs; outputs reflect the state being entered.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        wcnt_d  = wcnt_q;
        op_d    = op_q;
        key_d   = key_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        wmask_d = 4'd0;
        addr_d  = 8'd0;
        wdata_d = 32'd0;
        rv_d    = 1'b0;
        hit_d   = 1'b0;
        ridx_d  = 6'd0;
        vec_d   = 64'd0;
        half    = idx_q[5] ? in_tcam_rdata[63:32] : in_tcam_rdata[31:0];
        bit_b   = (op_q == OP_WRITE) && (((a_q ^ key_q) & mask_q) == 7'd0);

        case (state_q)
            IDLE: if (in_req_valid && ready_q) begin
                op_d   = in_req_op;
                key_d  = in_req_key;
                mask_d = in_req_mask;
                idx_d  = in_req_idx;
                a_d    = 7'd0;
                case (in_req_op)
                    OP_SEARCH: begin
                        state_d = S_RD;
                        csb_d   = 1'b0;
                        addr_d  = {1'b0, in_req_key};
                    end
                    OP_WRITE, OP_DELETE: begin
                        state_d = P_RD;
                        csb_d   = 1'b0;
                        addr_d  = 8'd0;
                    end
                    default: begin
                        state_d = RSP;
                        rv_d    = 1'b1;
                    end
                endcase
            end
            S_RD: begin
                state_d = S_WAIT;
                wcnt_d  = '0;
            end
            S_WAIT: begin
                if (wcnt_q == WLAST) begin
                    state_d = RSP;
                    rv_d    = 1'b1;
                    vec_d   = in_tcam_rdata;
                    hit_d   = |in_tcam_rdata;
                    ridx_d  = lsb_idx(in_tcam_rdata);
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            RSP: state_d = IDLE;
            P_RD: begin
                state_d = P_WAIT;
                wcnt_d  = '0;
            end
            P_WAIT: begin
                if (wcnt_q == WLAST) begin
                    state_d = P_WR;
                    csb_d   = 1'b0;
                    web_d   = 1'b0;
                    addr_d  = {idx_q[5], a_q};
                    wmask_d = 4'b0001 << idx_q[4:3];
                    wdata_d = half;
                    wdata_d[idx_q[4:0]] = bit_b;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            P_WR: begin
                if (a_q == 7'd127) begin
                    state_d = RSP;
                    rv_d    = 1'b1;
                    ridx_d  = idx_q;
                end else begin
                    a_d     = a_q + 7'd1;
                    state_d = P_RD;
                    csb_d   = 1'b0;
                    addr_d  = {1'b0, 7'(a_q + 7'd1)};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and output registers; reset abandons any sweep in flight.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            wcnt_q  <= '0;
            op_q    <= '0;
            key_q   <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rv_q    <= 1'b0;
            hit_q   <= 1'b0;
            ridx_q  <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            wcnt_q  <= wcnt_d;
            op_q    <= op_d;
            key_q   <= key_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rv_q    <= rv_d;
            hit_q   <= hit_d;
            ridx_q  <= ridx_d;
            vec_q   <= vec_d;
        end
    end

    assign out_req_ready  = ready_q;
    assign out_busy       = busy_q;
    assign out_tcam_csb   = csb_q;
    assign out_tcam_web   = web_q;
    assign out_tcam_wmask = wmask_q;
    assign out_tcam_addr  = addr_q;
    assign out_tcam_wdata = wdata_q;
    assign out_rsp_valid  = rv_q;
    assign out_rsp_hit    = hit_q;
    assign out_rsp_idx    = ridx_q;
    assign out_rsp_vec    = vec_q;

endmodule

// File: tb/tb_tcam_ctrl7x64.sv
// Scoreboard bench for tcam_ctrl7x64: a behavioural TCAM entry table predicts each
// response; a macro model sits behind the DUT; a monitor pops and compares.
module tb_tcam_ctrl7x64;

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b1;
    logic        in_req_valid = 1'b0;
    logic        out_req_ready;
    logic [1:0]  in_req_op = '0;
    logic [6:0]  in_req_key = '0;
    logic [6:0]  in_req_mask = '0;
    logic [5:0]  in_req_idx = '0;
    logic        out_rsp_valid, out_rsp_hit, out_busy;
    logic [5:0]  out_rsp_idx;
    logic [63:0] out_rsp_vec;
    logic        out_tcam_csb, out_tcam_web;
    logic [3:0]  out_tcam_wmask;
    logic [7:0]  out_tcam_addr;
    logic [31:0] out_tcam_wdata;
    logic [63:0] in_tcam_rdata = '0;

    tcam_ctrl7x64 #(.RD_LAT(1)) dut (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_req_valid(in_req_valid), .out_req_ready(out_req_ready),
        .in_req_op(in_req_op), .in_req_key(in_req_key),
        .in_req_mask(in_req_mask), .in_req_idx(in_req_idx),
        .out_rsp_valid(out_rsp_valid), .out_rsp_hit(out_rsp_hit),
        .out_rsp_idx(out_rsp_idx), .out_rsp_vec(out_rsp_vec),
        .out_busy(out_busy),
        .out_tcam_csb(out_tcam_csb), .out_tcam_web(out_tcam_web),
        .out_tcam_wmask(out_tcam_wmask), .out_tcam_addr(out_tcam_addr),
        .out_tcam_wdata(out_tcam_wdata), .in_tcam_rdata(in_tcam_rdata)
    );

    always #5 in_clk = ~in_clk;

    int cyc = 0;
    always @(posedge in_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Macro model: 256 x 32 rows, byte-masked writes, one-cycle read of both halves.
    logic [31:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge in_clk) begin
        if (!out_tcam_csb) begin
            if (!out_tcam_web) begin
                for (int b = 0; b < 4; b++)
                    if (out_tcam_wmask[b]) mem[out_tcam_addr][8*b +: 8] <= out_tcam_wdata[8*b +: 8];
            end else begin
                in_tcam_rdata <= {mem[{1'b1, out_tcam_addr[6:0]}], mem[{1'b0, out_tcam_addr[6:0]}]};
            end
        end
    end

    // Reference: entry table, matched against a key with plain mask arithmetic.
    bit         ent_v [64];
    logic [6:0] ent_k [64];
    logic [6:0] ent_m [64];
    initial for (int e = 0; e < 64; e++) begin ent_v[e] = 0; ent_k[e] = '0; ent_m[e] = '0; end

    function automatic logic [63:0] ref_vec(input logic [6:0] k);
        logic [63:0] v;
        v = '0;
        for (int e = 0; e < 64; e++)
            if (ent_v[e] && (((k ^ ent_k[e]) & ent_m[e]) == 7'd0)) v[e] = 1'b1;
        return v;
    endfunction

    function automatic logic [5:0] first_set(input logic [63:0] v);
        logic found;
        logic [5:0] r;
        found = 0; r = '0;
        for (int i = 0; i < 64; i++)
            if (!found && v[i]) begin found = 1; r = 6'(i); end
        return r;
    endfunction

    typedef struct {
        logic        hit;
        logic [5:0]  idx;
        logic [63:0] vec;
        int          acc_cyc;
        int          lat;
        int          acc;
        int          wr;
        logic [3:0]  wm;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: counts macro accesses per request and checks every response pulse.
    int acc_n = 0, wr_n = 0, wm_bad = 0;
    always @(negedge in_clk) begin
        exp_t e;
        if (in_rst) begin
            acc_n = 0; wr_n = 0; wm_bad = 0;
        end else begin
            chk("busy_vs_ready", {63'd0, out_busy}, {63'd0, !out_req_ready});
            if (!out_tcam_csb) acc_n++;
            if (!out_tcam_csb && !out_tcam_web) begin
                wr_n++;
                if (q.size() > 0 && out_tcam_wmask != q[0].wm) wm_bad++;
            end
            if (out_rsp_valid) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("rsp_hit", {63'd0, out_rsp_hit}, {63'd0, e.hit});
                    chk("rsp_idx", {58'd0, out_rsp_idx}, {58'd0, e.idx});
                    chk("rsp_vec", out_rsp_vec, e.vec);
                    chk("rsp_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                    chk("access_cycles", 64'(acc_n), 64'(e.acc));
                    chk("write_cycles", 64'(wr_n), 64'(e.wr));
                    chk("wmask_bad", 64'(wm_bad), 64'd0);
                end
                acc_n = 0; wr_n = 0; wm_bad = 0;
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        @(negedge in_clk);
        while (!out_req_ready && n < 20) begin @(negedge in_clk); n++; end
        ok = out_req_ready;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1 (cycle %0d)", cyc);
        end
    endtask

    // Issue one request, predict its response, then hold junk on the request
    // inputs until the response pulse (it must be ignored).
    task automatic do_req(input logic [1:0] op, input logic [6:0] key, input logic [6:0] mask,
                          input logic [5:0] idx);
        exp_t e;
        bit ok, got;
        int n;
        logic [63:0] v;
        wait_ready(ok);
        if (!ok) return;
        in_req_valid = 1'b1; in_req_op = op; in_req_key = key;
        in_req_mask = mask; in_req_idx = idx;
        @(posedge in_clk);
        e.acc_cyc = cyc;
        e.wm = 4'd0;
        if (op == 2'd0) begin
            v = ref_vec(key);
            e.hit = |v; e.vec = v; e.idx = first_set(v);
            e.lat = 3; e.acc = 1; e.wr = 0;
        end else if (op == 2'd3) begin
            e.hit = 0; e.vec = '0; e.idx = '0;
            e.lat = 1; e.acc = 0; e.wr = 0;
        end else begin
            ent_v[idx] = (op == 2'd1); ent_k[idx] = key; ent_m[idx] = mask;
            e.hit = 0; e.vec = '0; e.idx = idx;
            e.lat = 385; e.acc = 256; e.wr = 128;
            e.wm = 4'b0001 << idx[4:3];
        end
        q.push_back(e);
        got = 0; n = 0;
        while (!got && n < 500) begin
            @(negedge in_clk); n++;
            if (out_rsp_valid) got = 1;
            else begin
                in_req_valid = 1'($urandom_range(0, 1));
                in_req_op = 2'($urandom); in_req_key = 7'($urandom);
                in_req_mask = 7'($urandom); in_req_idx = 6'($urandom);
            end
        end
        in_req_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one within 500 cycles (cycle %0d)", cyc);
            q.delete();
        end
    endtask

    initial begin
        bit ok;
        logic [5:0] ri;
        repeat (3) @(negedge in_clk);
        chk("reset_csb",   {63'd0, out_tcam_csb},  64'd1);
        chk("reset_web",   {63'd0, out_tcam_web},  64'd1);
        chk("reset_wmask", {60'd0, out_tcam_wmask}, 64'd0);
        chk("reset_rsp_valid", {63'd0, out_rsp_valid}, 64'd0);
        chk("reset_busy",  {63'd0, out_busy}, 64'd0);
        in_rst = 1'b0;
        @(negedge in_clk);
        chk("ready_after_reset", {63'd0, out_req_ready}, 64'd1);

        do_req(2'd1, 7'h2A, 7'h7F, 6'd5);
        do_req(2'd0, 7'h2A, 7'h00, 6'd0);
        do_req(2'd0, 7'h2B, 7'h00, 6'd0);
        do_req(2'd1, 7'h00, 7'h00, 6'd40);
        do_req(2'd0, 7'h55, 7'h00, 6'd0);
        do_req(2'd0, 7'h2A, 7'h00, 6'd0);
        do_req(2'd2, 7'h00, 7'h00, 6'd5);
        do_req(2'd0, 7'h2A, 7'h00, 6'd0);
        do_req(2'd2, 7'h00, 7'h00, 6'd40);
        for (int i = 0; i < 8; i++) do_req(2'd1, 7'(i), 7'h7F, 6'(i));
        for (int i = 0; i < 8; i++) do_req(2'd0, 7'(i), 7'h00, 6'd0);

        // Reset 100 cycles into an identical rewrite of entry 3 (table unchanged).
        wait_ready(ok);
        in_req_valid = 1'b1; in_req_op = 2'd1; in_req_key = 7'd3;
        in_req_mask = 7'h7F; in_req_idx = 6'd3;
        @(posedge in_clk);
        @(negedge in_clk);
        in_req_valid = 1'b0;
        repeat (99) @(negedge in_clk);
        in_rst = 1'b1;
        @(negedge in_clk);
        chk("midrst_csb",  {63'd0, out_tcam_csb}, 64'd1);
        chk("midrst_busy", {63'd0, out_busy}, 64'd0);
        chk("midrst_rsp_valid", {63'd0, out_rsp_valid}, 64'd0);
        in_rst = 1'b0;
        do_req(2'd0, 7'd3, 7'h00, 6'd0);
        do_req(2'd3, 7'h11, 7'h22, 6'd9);

        // Randomized phase.
        for (int r = 0; r < 8; r++) begin
            ri = 6'($urandom);
            if ($urandom_range(0, 3) != 0)
                do_req(2'd1, 7'($urandom), 7'($urandom), ri);
            else
                do_req(2'd2, 7'($urandom), 7'($urandom), ri);
            for (int s = 0; s < 3; s++) begin
                ri = 6'($urandom);
                if (ent_v[ri] && $urandom_range(0, 1) == 1)
                    do_req(2'd0, ent_k[ri] ^ (7'($urandom) & ~ent_m[ri]), 7'd0, 6'd0);
                else
                    do_req(2'd0, 7'($urandom), 7'd0, 6'd0);
            end
            if (r % 4 == 0) do_req(2'd3, 7'($urandom), 7'($urandom), 6'($urandom));
        end

        repeat (5) @(negedge in_clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
